// File: rtl/tl_cntr_timed.sv
// rtl/tl_cntr_timed.sv - two-road traffic-light controller with left-turn phases, min/max green and night flash
module tl_cntr_timed #(
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 30,
    parameter int YELLOW_CYC = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    input  logic       night,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_AG    = 4'd0,
        S_AY    = 4'd1,
        S_AL    = 4'd2,
        S_ALY   = 4'd3,
        S_BG    = 4'd4,
        S_BY    = 4'd5,
        S_BL    = 4'd6,
        S_BLY   = 4'd7,
        S_NIGHT = 4'd8
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;
    localparam logic [1:0] L_LEFT   = 2'b11;

    localparam logic [CNT_W-1:0] C_MIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL_M1 = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_SAT    = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_blink;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_blink_nxt;
    logic             w_min_ok;
    logic             w_max_ok;
    logic             w_yel_end;

    assign w_min_ok  = (r_timer >= C_MIN_M1);
    assign w_max_ok  = (r_timer >= C_MAX_M1);
    assign w_yel_end = (r_timer == C_YEL_M1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_AG;
            r_timer <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_AG: begin
                if (w_min_ok && (!Ta || (w_max_ok && (Tal || Tb || Tbl))))
                    w_state_nxt = S_AY;
            end
            S_AL: begin
                if (w_min_ok && (!Tal || (w_max_ok && (Ta || Tb || Tbl))))
                    w_state_nxt = S_ALY;
            end
            S_BG: begin
                if (w_min_ok && (!Tb || (w_max_ok && (Tbl || Ta || Tal))))
                    w_state_nxt = S_BY;
            end
            S_BL: begin
                if (w_min_ok && (!Tbl || (w_max_ok && (Tb || Ta || Tal))))
                    w_state_nxt = S_BLY;
            end
            S_AY: begin
                if (w_yel_end)
                    w_state_nxt = night ? S_NIGHT : (Tal ? S_AL : S_BG);
            end
            S_ALY: begin
                if (w_yel_end)
                    w_state_nxt = night ? S_NIGHT : S_BG;
            end
            S_BY: begin
                if (w_yel_end)
                    w_state_nxt = night ? S_NIGHT : (Tbl ? S_BL : S_AG);
            end
            S_BLY: begin
                if (w_yel_end)
                    w_state_nxt = night ? S_NIGHT : S_AG;
            end
            S_NIGHT: begin
                if (w_yel_end && !night)
                    w_state_nxt = S_AG;
            end
            default: w_state_nxt = S_AG;
        endcase
    end

    // Timer restarts on any state change and on each night blink boundary.
    always_comb begin
        w_timer_nxt = r_timer;
        w_blink_nxt = 1'b0;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
            w_blink_nxt = (w_state_nxt == S_NIGHT);
        end else if (r_state == S_NIGHT) begin
            if (w_yel_end) begin
                w_timer_nxt = '0;
                w_blink_nxt = !r_blink;
            end else begin
                w_timer_nxt = r_timer + 1'b1;
                w_blink_nxt = r_blink;
            end
        end else if (r_timer != C_SAT) begin
            w_timer_nxt = r_timer + 1'b1;
        end
    end

    always_comb begin
        La    = L_RED;
        Lb    = L_RED;
        phase = r_state;
        case (r_state)
            S_AG:    La = L_GREEN;
            S_AY:    La = L_YELLOW;
            S_AL:    La = L_LEFT;
            S_ALY:   La = L_YELLOW;
            S_BG:    Lb = L_GREEN;
            S_BY:    Lb = L_YELLOW;
            S_BL:    Lb = L_LEFT;
            S_BLY:   Lb = L_YELLOW;
            S_NIGHT: begin
                La = r_blink ? L_YELLOW : L_RED;
                Lb = r_blink ? L_YELLOW : L_RED;
            end
            default: begin
                La = L_RED;
                Lb = L_RED;
            end
        endcase
    end

endmodule
